// File: rtl/lstm_4step_pipeline.sv
// Single-unit Q6.11 LSTM cell unrolled over four steps.
// One sequence per clock in, final (c4, h4) four clocks later.

module lstm_step_stage #(
  parameter int WIDTH = 18,
  parameter int FRAC  = 11
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] h,
  input  logic signed [WIDTH-1:0] w_fx,
  input  logic signed [WIDTH-1:0] w_fh,
  input  logic signed [WIDTH-1:0] b_f,
  input  logic signed [WIDTH-1:0] w_ix,
  input  logic signed [WIDTH-1:0] w_ih,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic signed [WIDTH-1:0] w_gx,
  input  logic signed [WIDTH-1:0] w_gh,
  input  logic signed [WIDTH-1:0] b_g,
  input  logic signed [WIDTH-1:0] w_ox,
  input  logic signed [WIDTH-1:0] w_oh,
  input  logic signed [WIDTH-1:0] b_o,
  output logic signed [WIDTH-1:0] c_nxt,
  output logic signed [WIDTH-1:0] h_nxt
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW - FRAC + 2;

  typedef logic signed [WIDTH-1:0] dat_t;
  typedef logic signed [SW-1:0]    sum_t;
  typedef logic signed [WIDTH:0]   hs_t;

  localparam sum_t SMAX = sum_t'((1 <<< (WIDTH - 1)) - 1);
  localparam sum_t SMIN = sum_t'(-(1 <<< (WIDTH - 1)));
  localparam dat_t ONE  = dat_t'(1 <<< FRAC);
  localparam dat_t NONE = dat_t'(-(1 <<< FRAC));
  localparam hs_t  HALF = hs_t'(1 <<< (FRAC - 1));
  localparam hs_t  ONEW = hs_t'(1 <<< FRAC);

  // Sums are kept wide enough that no product or sum can wrap
  // before the final saturation.
  function automatic sum_t mul(input dat_t a, input dat_t b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return sum_t'(p >>> FRAC);
  endfunction

  function automatic sum_t ext(input dat_t a);
    return sum_t'(a);
  endfunction

  function automatic dat_t sat(input sum_t s);
    dat_t r;
    if (s > SMAX)
      r = dat_t'(SMAX);
    else if (s < SMIN)
      r = dat_t'(SMIN);
    else
      r = dat_t'(s);
    return r;
  endfunction

  function automatic dat_t hsig(input dat_t z);
    hs_t  t;
    dat_t r;
    t = hs_t'(z >>> 2) + HALF;
    if (t < 0)
      r = '0;
    else if (t > ONEW)
      r = ONE;
    else
      r = dat_t'(t);
    return r;
  endfunction

  function automatic dat_t htanh(input dat_t z);
    dat_t r;
    if (z > ONE)
      r = ONE;
    else if (z < NONE)
      r = NONE;
    else
      r = z;
    return r;
  endfunction

  dat_t f_g;
  dat_t i_g;
  dat_t g_g;
  dat_t o_g;
  dat_t c_t;

  assign f_g = hsig(sat(mul(w_fx, x) + mul(w_fh, h) + ext(b_f)));
  assign i_g = hsig(sat(mul(w_ix, x) + mul(w_ih, h) + ext(b_i)));
  assign g_g = htanh(sat(mul(w_gx, x) + mul(w_gh, h) + ext(b_g)));
  assign o_g = hsig(sat(mul(w_ox, x) + mul(w_oh, h) + ext(b_o)));

  assign c_nxt = sat(mul(f_g, c) + mul(i_g, g_g));
  assign c_t   = htanh(c_nxt);
  assign h_nxt = sat(mul(o_g, c_t));

endmodule

module lstm_4step_pipeline #(
  parameter int WIDTH = 18,
  parameter int FRAC  = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] x2,
  input  logic signed [WIDTH-1:0] x3,
  input  logic signed [WIDTH-1:0] x4,
  input  logic signed [WIDTH-1:0] c0,
  input  logic signed [WIDTH-1:0] h0,
  input  logic signed [WIDTH-1:0] W_fx,
  input  logic signed [WIDTH-1:0] W_fh,
  input  logic signed [WIDTH-1:0] b_f,
  input  logic signed [WIDTH-1:0] W_ix,
  input  logic signed [WIDTH-1:0] W_ih,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic signed [WIDTH-1:0] W_gx,
  input  logic signed [WIDTH-1:0] W_gh,
  input  logic signed [WIDTH-1:0] b_g,
  input  logic signed [WIDTH-1:0] W_ox,
  input  logic signed [WIDTH-1:0] W_oh,
  input  logic signed [WIDTH-1:0] b_o,
  output logic signed [WIDTH-1:0] c4_out,
  output logic signed [WIDTH-1:0] h4_out
);

  typedef logic signed [WIDTH-1:0] dat_t;

  dat_t c1_q, h1_q;
  dat_t c2_q, h2_q;
  dat_t c3_q, h3_q;
  dat_t x2_d1;
  dat_t x3_d1, x3_d2;
  dat_t x4_d1, x4_d2, x4_d3;

  dat_t c1_n, h1_n;
  dat_t c2_n, h2_n;
  dat_t c3_n, h3_n;
  dat_t c4_n, h4_n;

  // Weights are shared live by all stages; in-flight sequences
  // see a weight change immediately.
  lstm_step_stage #(.WIDTH(WIDTH), .FRAC(FRAC)) u_s1 (
    .x(x1), .c(c0), .h(h0),
    .w_fx(W_fx), .w_fh(W_fh), .b_f(b_f),
    .w_ix(W_ix), .w_ih(W_ih), .b_i(b_i),
    .w_gx(W_gx), .w_gh(W_gh), .b_g(b_g),
    .w_ox(W_ox), .w_oh(W_oh), .b_o(b_o),
    .c_nxt(c1_n), .h_nxt(h1_n)
  );

  lstm_step_stage #(.WIDTH(WIDTH), .FRAC(FRAC)) u_s2 (
    .x(x2_d1), .c(c1_q), .h(h1_q),
    .w_fx(W_fx), .w_fh(W_fh), .b_f(b_f),
    .w_ix(W_ix), .w_ih(W_ih), .b_i(b_i),
    .w_gx(W_gx), .w_gh(W_gh), .b_g(b_g),
    .w_ox(W_ox), .w_oh(W_oh), .b_o(b_o),
    .c_nxt(c2_n), .h_nxt(h2_n)
  );

  lstm_step_stage #(.WIDTH(WIDTH), .FRAC(FRAC)) u_s3 (
    .x(x3_d2), .c(c2_q), .h(h2_q),
    .w_fx(W_fx), .w_fh(W_fh), .b_f(b_f),
    .w_ix(W_ix), .w_ih(W_ih), .b_i(b_i),
    .w_gx(W_gx), .w_gh(W_gh), .b_g(b_g),
    .w_ox(W_ox), .w_oh(W_oh), .b_o(b_o),
    .c_nxt(c3_n), .h_nxt(h3_n)
  );

  lstm_step_stage #(.WIDTH(WIDTH), .FRAC(FRAC)) u_s4 (
    .x(x4_d3), .c(c3_q), .h(h3_q),
    .w_fx(W_fx), .w_fh(W_fh), .b_f(b_f),
    .w_ix(W_ix), .w_ih(W_ih), .b_i(b_i),
    .w_gx(W_gx), .w_gh(W_gh), .b_g(b_g),
    .w_ox(W_ox), .w_oh(W_oh), .b_o(b_o),
    .c_nxt(c4_n), .h_nxt(h4_n)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c1_q   <= '0;
      h1_q   <= '0;
      c2_q   <= '0;
      h2_q   <= '0;
      c3_q   <= '0;
      h3_q   <= '0;
      c4_out <= '0;
      h4_out <= '0;
      x2_d1  <= '0;
      x3_d1  <= '0;
      x3_d2  <= '0;
      x4_d1  <= '0;
      x4_d2  <= '0;
      x4_d3  <= '0;
    end else begin
      c1_q   <= c1_n;
      h1_q   <= h1_n;
      c2_q   <= c2_n;
      h2_q   <= h2_n;
      c3_q   <= c3_n;
      h3_q   <= h3_n;
      c4_out <= c4_n;
      h4_out <= h4_n;
      x2_d1  <= x2;
      x3_d1  <= x3;
      x3_d2  <= x3_d1;
      x4_d1  <= x4;
      x4_d2  <= x4_d1;
      x4_d3  <= x4_d2;
    end
  end

endmodule

// File: tb/tb_lstm_4step_pipeline.sv
// Bench for lstm_4step_pipeline: vector table, scoreboard queue,
// and hand sequences for latency, throughput and async reset.

module tb_lstm_4step_pipeline;

  logic clk = 1'b0;
  logic rst;
  logic signed [17:0] x1, x2, x3, x4, c0, h0;
  logic signed [17:0] w_fx, w_fh, b_f, w_ix, w_ih, b_i;
  logic signed [17:0] w_gx, w_gh, b_g, w_ox, w_oh, b_o;
  logic signed [17:0] c4_out, h4_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x [4];
    int c0;
    int h0;
    int w [12];
    int ec;
    int eh;
    string nm;
  } vec_t;

  typedef struct {
    bit    v;
    int    c;
    int    h;
    string nm;
  } exp_t;

  exp_t sb [$];
  vec_t tbl [6];

  always #5 clk = ~clk;

  lstm_4step_pipeline dut (
    .clk(clk), .rst(rst),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .c0(c0), .h0(h0),
    .W_fx(w_fx), .W_fh(w_fh), .b_f(b_f),
    .W_ix(w_ix), .W_ih(w_ih), .b_i(b_i),
    .W_gx(w_gx), .W_gh(w_gh), .b_g(b_g),
    .W_ox(w_ox), .W_oh(w_oh), .b_o(b_o),
    .c4_out(c4_out), .h4_out(h4_out)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    x1 = 18'(v.x[0]);
    x2 = 18'(v.x[1]);
    x3 = 18'(v.x[2]);
    x4 = 18'(v.x[3]);
    c0 = 18'(v.c0);
    h0 = 18'(v.h0);
    w_fx = 18'(v.w[0]);
    w_fh = 18'(v.w[1]);
    b_f  = 18'(v.w[2]);
    w_ix = 18'(v.w[3]);
    w_ih = 18'(v.w[4]);
    b_i  = 18'(v.w[5]);
    w_gx = 18'(v.w[6]);
    w_gh = 18'(v.w[7]);
    b_g  = 18'(v.w[8]);
    w_ox = 18'(v.w[9]);
    w_oh = 18'(v.w[10]);
    b_o  = 18'(v.w[11]);
  endtask

  task automatic zero_seq();
    x1 = '0; x2 = '0; x3 = '0; x4 = '0;
    c0 = '0; h0 = '0;
  endtask

  task automatic rand_all();
    {x1, x2, x3, x4} = {$urandom, $urandom, $urandom};
    {c0, h0} = 36'($urandom) ^ {18'h0, 18'($urandom)};
    {w_fx, w_fh, b_f, w_ix} = {$urandom, $urandom, $urandom};
    {w_ih, b_i, w_gx, w_gh} = {$urandom, $urandom, $urandom};
    {b_g, w_ox, w_oh, b_o} = {$urandom, $urandom, $urandom};
  endtask

  // One clock: record what is being launched this edge, retire
  // the entry launched three edges earlier and compare it.
  task automatic tick(input bit v, input int ec, input int eh,
                      input string nm);
    exp_t e;
    exp_t o;
    @(posedge clk);
    e.v = v; e.c = ec; e.h = eh; e.nm = nm;
    sb.push_back(e);
    #1;
    if (sb.size() == 4) begin
      o = sb.pop_front();
      if (o.v) begin
        chk({o.nm, "_c4"}, int'(c4_out), o.c);
        chk({o.nm, "_h4"}, int'(h4_out), o.h);
      end
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++)
      tick(1'b0, 0, 0, "bubble");
  endtask

  initial begin
    tbl[0] = '{x: '{2048, 1024, 512, 2048}, c0: 0, h0: 0,
      w: '{3333, 5529, 3318, 3379, 4096, 1269,
           1923, 2891, -655, -389, 8970, 1208},
      ec: 6742, eh: 2048, nm: "ref"};
    tbl[1] = '{x: '{0, 0, 0, 0}, c0: 0, h0: 0,
      w: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      ec: 0, eh: 0, nm: "zero_w"};
    tbl[2] = '{x: '{0, 0, 0, 0}, c0: 122880, h0: 0,
      w: '{0, 0, 8192, 0, 0, 8192, 0, 0, 8192, 0, 0, 8192},
      ec: 131071, eh: 2048, nm: "c_sat"};
    tbl[3] = '{x: '{0, 0, 0, 0}, c0: 0, h0: 0,
      w: '{0, 0, 8192, 0, 0, 8192, 0, 0, -8192, 0, 0, 8192},
      ec: -8192, eh: -2048, nm: "neg"};
    tbl[4] = '{x: '{0, 0, 0, 0}, c0: 0, h0: 0,
      w: '{3333, 5529, 3318, 3379, 4096, 1269,
           1923, 2891, -655, -389, 8970, 1208},
      ec: -1784, eh: -620, nm: "ref_w_zero_in"};
    tbl[5] = '{x: '{0, 0, 0, 0}, c0: 1000, h0: 0,
      w: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      ec: 62, eh: 31, nm: "decay"};

    rst = 1'b0;
    rand_all();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c4", int'(c4_out), 0);
    chk("rst_h4", int'(h4_out), 0);
    rand_all();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rand_c4", int'(c4_out), 0);
    chk("rst_rand_h4", int'(h4_out), 0);
    @(negedge clk);
    rst = 1'b1;

    // Each table vector runs alone since weights change between them.
    foreach (tbl[n]) begin
      apply(tbl[n]);
      tick(1'b1, tbl[n].ec, tbl[n].eh, tbl[n].nm);
      zero_seq();
      drain(3);
    end

    // Reference then zero sequence back to back, with stage probes.
    apply(tbl[0]);
    tick(1'b1, 6742, 2048, "lat_ref");
    chk("c1", int'(dut.c1_q), 1268);
    chk("h1", int'(dut.h1_q), 760);
    zero_seq();
    tick(1'b1, -1784, -620, "lat_zero");
    chk("c2", int'(dut.c2_q), 2646);
    chk("h2", int'(dut.h2_q), 2048);
    chk("c1_second", int'(dut.c1_q), -429);
    chk("h1_second", int'(dut.h1_q), -278);
    tick(1'b0, 0, 0, "bubble");
    chk("c3", int'(dut.c3_q), 4694);
    drain(3);

    // Alternating stream at full rate.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        apply(tbl[0]);
        tick(1'b1, 6742, 2048, "stream_ref");
      end else begin
        zero_seq();
        tick(1'b1, -1784, -620, "stream_zero");
      end
    end
    zero_seq();
    drain(3);

    // Async reset between edges with sequences in flight.
    apply(tbl[0]);
    for (int k = 0; k < 5; k++)
      tick(1'b0, 0, 0, "fill");
    chk("pre_rst_c4", int'(c4_out), 6742);
    #3;
    rst = 1'b0;
    #1;
    chk("async_c4", int'(c4_out), 0);
    chk("async_h4", int'(h4_out), 0);
    chk("async_c1", int'(dut.c1_q), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply(tbl[0]);
    tick(1'b1, 6742, 2048, "post_rst_ref");
    zero_seq();
    tick(1'b1, -1784, -620, "post_rst_zero");
    drain(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lstm_4step_pipeline.md
# lstm_4step_pipeline

Fixed-point, single-unit LSTM cell unrolled over four time steps as a four-stage pipeline. Each stage evaluates one LSTM step in Q6.11, with hard-sigmoid and hard-tanh activations. The block is stateless: the initial cell/hidden state (c0, h0) and four inputs x1..x4 enter together, and the final state (c4, h4) leaves four clocks later. One new sequence can be accepted every clock. It sits in the datapath as a self-contained sequence evaluator with externally supplied, shared gate weights.

## Interface
- WIDTH, 18: data width of every port, two's-complement signed.
- FRAC, 11: fractional bits (Q6.11; 1.0 = 2048).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- x1, x2, x3, x4  in  WIDTH  inputs for steps 1..4, sampled on the same edge.
- c0, h0  in  WIDTH  initial cell and hidden state.
- W_fx, W_fh, b_f  in  WIDTH  forget-gate x-weight, h-weight, bias.
- W_ix, W_ih, b_i  in  WIDTH  input-gate weights and bias.
- W_gx, W_gh, b_g  in  WIDTH  candidate (g) weights and bias.
- W_ox, W_oh, b_o  in  WIDTH  output-gate weights and bias.
- c4_out, h4_out  out  WIDTH  registered final cell and hidden state.

## Operation
- Step k (k=1..4) takes x_k, c_{k-1}, h_{k-1} and computes the following:
  - f = hsig(W_fx*x + W_fh*h + b_f)
  - i = hsig(W_ix*x + W_ih*h + b_i)
  - g = htanh(W_gx*x + W_gh*h + b_g)
  - o = hsig(W_ox*x + W_oh*h + b_o)
  - c_k = f*c + i*g
  - h_k = o*htanh(c_k)
- Fixed-point multiply: full 2*WIDTH-bit signed product, then arithmetic shift right by FRAC (floor).
- Preactivation and c_k sums are formed at ≥ WIDTH+3 bits. Each result is saturated to [-131072, 131071].
- hsig(z) = clamp((z >>> 2) + 1024, 0, 2048), which is 0.25·z + 0.5 clamped to [0, 1].
- htanh(z) = clamp(z, -2048, 2048).
- The same 12 weight/bias ports feed all four stages. Weights are treated as static. A change propagates immediately to every stage, including sequences already in flight.
- No handshake. Every clock is a valid sample.

## Timing
- Stage 1 is combinational from the ports x1, c0, h0. It is registered into c1/h1 at edge n.
- On the same edge, x2, x3, x4 enter delay lines of 1, 2 and 3 registers. Stage k therefore sees the x_k belonging to the same sequence as its c_{k-1}/h_{k-1}.
- Stages 2, 3 and 4 register at edges n+1, n+2 and n+3.
- c4_out/h4_out change right after edge n+3 (latency 4 clocks). Throughput is 1 sequence per clock.
- While rst=0, all pipeline, delay and output registers read 0, asynchronously and immediately. c4_out = h4_out = 0.
- After release, the first 3 output updates are flush values computed from the zeroed registers. The first sequence presented at the first post-reset edge appears after the 4th edge.
- Asserting reset mid-operation discards all in-flight sequences.
- Saturation boundaries hold at every stage independently. A saturated c_k is the value carried to stage k+1.

## Test plan
- Reset: hold rst=0 with random inputs -> c4_out = h4_out = 0. Outputs also go to 0 asynchronously when rst falls between edges.
- Reference sequence: W_fx=3333, W_fh=5529, b_f=3318, W_ix=3379, W_ih=4096, b_i=1269, W_gx=1923, W_gh=2891, b_g=-655, W_ox=-389, W_oh=8970, b_o=1208. Inputs x=(2048, 1024, 512, 2048), c0=h0=0. Check internally (c1,h1)=(1268,760), (c2,h2)=(2646,2048), c3=4694. Required outputs c4_out=6742, h4_out=2048.
- Zero weights and biases, any x/c0/h0=0 -> f=i=o=1024, g=0. Required c4_out=0, h4_out=0.
- Cell saturation: all W=0, b_f=b_i=b_g=b_o=8192, c0=122880, h0=0. c grows by 2048 per step (124928, 126976, 129024). Required c4_out=131071 (saturated), h4_out=2048.
- Latency/throughput: apply the reference sequence, then the zero-state/zero-input sequence, on consecutive edges. Required: outputs 6742/2048 after edge n+3, followed by the second sequence's result after edge n+4. Nothing is dropped or duplicated.
- Negative path: all W=0, b_g=-8192, b_f=b_i=b_o=8192, c0=0 -> c4_out=-8192, h4_out=-2048.
